// File: rtl/skew_feeder.sv
// skew_feeder
//   Operand scheduler for an N x N systolic PE array. Each step accepts one
//   A column vector and one B row vector together over a joint valid/ready
//   handshake. Lane i of each vector goes onto the array edge i+1 cycles after
//   it is accepted, which produces the diagonal skew the array needs. Cycles
//   with no accepted step inject zeros on every lane. After K steps the block
//   flushes the array for 2N cycles and then pulses done_o for one cycle.
//
// Ports
//   clk_i      clock
//   rst_i      synchronous reset, active-high
//   start_i    begin a tile (only honoured in IDLE); len_i is sampled with it
//   len_i      number of steps K for the tile; 0 is ignored, values are clipped to K_MAX
//   a_valid_i  A vector available        a_ready_o  A vector consumed this cycle
//   a_data_i   A column, element i -> west lane i
//   b_valid_i  B vector available        b_ready_o  B vector consumed this cycle
//   b_data_i   B row, element j -> north lane j
//   west_o     skewed west edge inputs   north_o    skewed north edge inputs
//   busy_o     tile in progress          done_o     one-cycle tile-complete pulse
module skew_feeder #(
  parameter  int N        = 4,
  parameter  int NUM_BITS = 16,
  parameter  int K_MAX    = 64,
  localparam int LW       = $clog2(K_MAX + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [LW-1:0]                 len_i,
  input  logic                          a_valid_i,
  output logic                          a_ready_o,
  input  logic [N-1:0][NUM_BITS-1:0]    a_data_i,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  input  logic [N-1:0][NUM_BITS-1:0]    b_data_i,
  output logic [N-1:0][NUM_BITS-1:0]    west_o,
  output logic [N-1:0][NUM_BITS-1:0]    north_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int FW = (2 * N > 1) ? $clog2(2 * N) : 1;

  localparam logic [LW-1:0]       K_MAX_LW   = LW'(K_MAX);
  localparam logic [LW-1:0]       ONE_LW     = LW'(1);
  localparam logic [LW-1:0]       ZERO_LW    = {LW{1'b0}};
  localparam logic [FW-1:0]       FLUSH_LAST = FW'(2 * N - 1);
  localparam logic [FW-1:0]       ONE_FW     = FW'(1);
  localparam logic [FW-1:0]       ZERO_FW    = {FW{1'b0}};
  localparam logic [NUM_BITS-1:0] ZERO_D     = {NUM_BITS{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [LW-1:0] k_r, k_s;
  logic [LW-1:0] step_cnt_r, step_cnt_s;
  logic [FW-1:0] flush_cnt_r, flush_cnt_s;
  logic [LW-1:0] len_clip_s;
  logic          step_s;

  // A step needs both operands at once; a lone valid is simply held off.
  assign step_s     = (state_r == FEED) && a_valid_i && b_valid_i;
  assign a_ready_o  = step_s;
  assign b_ready_o  = step_s;
  assign len_clip_s = (len_i > K_MAX_LW) ? K_MAX_LW : len_i;

  assign busy_o = (state_r != IDLE);
  assign done_o = (state_r == DONE);

  // Next-state and counter update logic for the tile sequencer.
  always_comb begin
    state_s     = state_r;
    k_s         = k_r;
    step_cnt_s  = step_cnt_r;
    flush_cnt_s = flush_cnt_r;
    case (state_r)
      IDLE: begin
        if (start_i && (len_i != ZERO_LW)) begin
          state_s    = FEED;
          k_s        = len_clip_s;
          step_cnt_s = ZERO_LW;
        end else begin
          state_s = IDLE;
        end
      end
      FEED: begin
        if (step_s) begin
          step_cnt_s = step_cnt_r + ONE_LW;
          // The K-th accept moves straight to FLUSH on the next cycle.
          if ((step_cnt_r + ONE_LW) == k_r) begin
            state_s     = FLUSH;
            flush_cnt_s = ZERO_FW;
          end else begin
            state_s = FEED;
          end
        end else begin
          state_s = FEED;
        end
      end
      FLUSH: begin
        // 2N cycles push the last skewed vector through the whole array.
        if (flush_cnt_r == FLUSH_LAST) begin
          state_s = DONE;
        end else begin
          flush_cnt_s = flush_cnt_r + ONE_FW;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      k_r         <= ZERO_LW;
      step_cnt_r  <= ZERO_LW;
      flush_cnt_r <= ZERO_FW;
    end else begin
      state_r     <= state_s;
      k_r         <= k_s;
      step_cnt_r  <= step_cnt_s;
      flush_cnt_r <= flush_cnt_s;
    end
  end

  // Skew lines: lane i is a chain of i+1 registers that shifts every cycle,
  // so a bubble (zero) enters all lanes together and diagonals stay aligned.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [NUM_BITS-1:0] a_pipe_r [0:i];
    logic [NUM_BITS-1:0] b_pipe_r [0:i];

    // Shift register for west lane i and north lane i.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int d = 0; d <= i; d++) begin
          a_pipe_r[d] <= ZERO_D;
          b_pipe_r[d] <= ZERO_D;
        end
      end else begin
        a_pipe_r[0] <= step_s ? a_data_i[i] : ZERO_D;
        b_pipe_r[0] <= step_s ? b_data_i[i] : ZERO_D;
        for (int d = 1; d <= i; d++) begin
          a_pipe_r[d] <= a_pipe_r[d-1];
          b_pipe_r[d] <= b_pipe_r[d-1];
        end
      end
    end

    assign west_o[i]  = a_pipe_r[i];
    assign north_o[i] = b_pipe_r[i];
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder. A reference model keeps a queue of
// injected vectors (pushed as stimulus is applied, popped as they age off the
// last lane) and a behavioural tile sequencer; every cycle the DUT's edge
// outputs and control outputs are compared against it, plus scenario checks.
module tb_skew_feeder;
  localparam int N     = 4;
  localparam int W     = 16;
  localparam int K_MAX = 64;
  localparam int LW    = $clog2(K_MAX + 1);

  typedef logic [N-1:0][W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          a_valid, a_ready, b_valid, b_ready;
  vec_t          a_data, b_data, west, north;
  logic          busy, done;

  always #5 clk = ~clk;

  skew_feeder #(.N(N), .NUM_BITS(W), .K_MAX(K_MAX)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
    .west_o(west), .north_o(north), .busy_o(busy), .done_o(done)
  );

  // reference model: 0 idle, 1 feed, 2 flush, 3 done
  int   m_state, m_k, m_steps, m_flush;
  vec_t hist_a[$], hist_b[$];
  vec_t exp_west, exp_north;
  logic exp_ready, exp_busy, exp_done;
  vec_t obs_west, obs_north;
  logic obs_a_ready, obs_b_ready, obs_busy, obs_done;
  int   cyc, obs_cyc;
  int   n_checks, n_fail;

  // Advance one clock: predict this cycle's outputs, sample the DUT on the
  // falling edge, then update the model with the inputs seen at the rising edge.
  task automatic tick();
    logic st;
    exp_ready = (m_state == 1) && a_valid && b_valid;
    exp_busy  = (m_state != 0);
    exp_done  = (m_state == 3);
    for (int i = 0; i < N; i++) begin
      exp_west[i]  = hist_a[i][i];
      exp_north[i] = hist_b[i][i];
    end
    @(negedge clk);
    obs_west = west; obs_north = north;
    obs_a_ready = a_ready; obs_b_ready = b_ready;
    obs_busy = busy; obs_done = done; obs_cyc = cyc;
    st = exp_ready;
    if (rst) begin
      m_state = 0; m_k = 0; m_steps = 0; m_flush = 0;
      for (int i = 0; i < N; i++) begin
        hist_a[i] = '0;
        hist_b[i] = '0;
      end
    end else begin
      hist_a.push_front(st ? a_data : vec_t'(0));
      hist_b.push_front(st ? b_data : vec_t'(0));
      void'(hist_a.pop_back());
      void'(hist_b.pop_back());
      case (m_state)
        0: if (start && len != 0) begin
             m_k = (int'(len) > K_MAX) ? K_MAX : int'(len);
             m_steps = 0; m_state = 1;
           end
        1: if (st) begin
             m_steps++;
             if (m_steps == m_k) begin m_state = 2; m_flush = 0; end
           end
        2: if (m_flush == 2 * N - 1) m_state = 3; else m_flush++;
        default: m_state = 0;
      endcase
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      a_data[i] = 16'($urandom_range(1, 65535));
      b_data[i] = 16'($urandom_range(1, 65535));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0;
    a_valid = 1'b1; b_valid = 1'b1;
    rand_data();
    @(posedge clk); #1; cyc++;
    tick();
    n_checks++;
    if ({obs_west, obs_north} !== {exp_west, exp_north}) begin
      n_fail++;
      $display("FAIL reset_edges cyc=%0d got west=%h north=%h want west=%h north=%h",
               obs_cyc, obs_west, obs_north, exp_west, exp_north);
    end
    n_checks++;
    if ({obs_a_ready, obs_b_ready, obs_busy, obs_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl cyc=%0d got rdy=%b%b busy=%b done=%b want all 0",
               obs_cyc, obs_a_ready, obs_b_ready, obs_busy, obs_done);
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_single();
    int t = -1, done_at = -1;
    start = 1'b1; len = LW'(1);
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_data[i] = 16'(i + 1);
      b_data[i] = 16'(5 + i);
    end
    a_valid = 1'b1; b_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      n_checks++;
      if ({obs_west, obs_north} !== {exp_west, exp_north}) begin
        n_fail++;
        $display("FAIL single_skew cyc=%0d got west=%h north=%h want west=%h north=%h",
                 obs_cyc, obs_west, obs_north, exp_west, exp_north);
      end
      n_checks++;
      if ({obs_a_ready, obs_b_ready, obs_busy, obs_done} !== {exp_ready, exp_ready, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL single_ctrl cyc=%0d got rdy=%b%b busy=%b done=%b want rdy=%b busy=%b done=%b",
                 obs_cyc, obs_a_ready, obs_b_ready, obs_busy, obs_done, exp_ready, exp_busy, exp_done);
      end
      for (int i = 0; i < N; i++) begin
        if (t >= 0 && obs_cyc == t + 1 + i) begin
          n_checks++;
          if (obs_west[i] !== 16'(i + 1) || obs_north[i] !== 16'(5 + i)) begin
            n_fail++;
            $display("FAIL single_lane%0d cyc=%0d got west=%0d north=%0d want west=%0d north=%0d",
                     i, obs_cyc, obs_west[i], obs_north[i], i + 1, 5 + i);
          end
        end
      end
      if (obs_a_ready) begin
        t = obs_cyc; a_valid = 1'b0; b_valid = 1'b0;
      end
      if (obs_done) done_at = obs_cyc;
    end
    n_checks++;
    if (t < 0 || done_at != t + 2 * N + 1) begin
      n_fail++;
      $display("FAIL single_done got accept=%0d done=%0d want done=accept+%0d", t, done_at, 2 * N + 1);
    end
  endtask

  task automatic test_stall();
    int accepts = 0, last = -1, done_at = -1;
    start = 1'b1; len = LW'(3);
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rand_data();
      a_valid = (accepts < 3);
      b_valid = (accepts < 3) && !(c == 1 || c == 2);
      tick();
      n_checks++;
      if ({obs_west, obs_north} !== {exp_west, exp_north}) begin
        n_fail++;
        $display("FAIL stall_skew cyc=%0d got west=%h north=%h want west=%h north=%h",
                 obs_cyc, obs_west, obs_north, exp_west, exp_north);
      end
      n_checks++;
      if ({obs_a_ready, obs_b_ready, obs_busy, obs_done} !== {exp_ready, exp_ready, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL stall_ctrl cyc=%0d got rdy=%b%b busy=%b done=%b want rdy=%b busy=%b done=%b",
                 obs_cyc, obs_a_ready, obs_b_ready, obs_busy, obs_done, exp_ready, exp_busy, exp_done);
      end
      if (obs_a_ready) begin accepts++; last = obs_cyc; end
      if (obs_done) done_at = obs_cyc;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_checks++;
    if (accepts != 3 || done_at != last + 2 * N + 1) begin
      n_fail++;
      $display("FAIL stall_count got accepts=%0d done=%0d want accepts=3 done=%0d",
               accepts, done_at, last + 2 * N + 1);
    end
  endtask

  task automatic test_len_limits();
    int accepts = 0, last = -1, done_at = -1;
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (obs_busy !== 1'b0 || obs_busy !== exp_busy) begin
      n_fail++;
      $display("FAIL len0_idle got busy=%b want 0", obs_busy);
    end
    start = 1'b1; len = LW'(K_MAX + 5);
    tick();
    for (int c = 0; c < K_MAX + 16; c++) begin
      rand_data();
      a_valid = 1'b1; b_valid = 1'b1;
      start = (c == 5 || c == 30);
      len = LW'(1);
      tick();
      n_checks++;
      if ({obs_west, obs_north} !== {exp_west, exp_north}) begin
        n_fail++;
        $display("FAIL kmax_skew cyc=%0d got west=%h north=%h want west=%h north=%h",
                 obs_cyc, obs_west, obs_north, exp_west, exp_north);
      end
      n_checks++;
      if ({obs_a_ready, obs_b_ready, obs_busy, obs_done} !== {exp_ready, exp_ready, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL kmax_ctrl cyc=%0d got rdy=%b%b busy=%b done=%b want rdy=%b busy=%b done=%b",
                 obs_cyc, obs_a_ready, obs_b_ready, obs_busy, obs_done, exp_ready, exp_busy, exp_done);
      end
      if (obs_a_ready) begin accepts++; last = obs_cyc; end
      if (obs_done) done_at = obs_cyc;
    end
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    n_checks++;
    if (accepts != K_MAX || done_at != last + 2 * N + 1) begin
      n_fail++;
      $display("FAIL kmax_count got accepts=%0d done=%0d want accepts=%0d done=%0d",
               accepts, done_at, K_MAX, last + 2 * N + 1);
    end
  endtask

  task automatic test_mid_reset();
    int accepts = 0, dones = 0, last = -1, done_at = -1;
    start = 1'b1; len = LW'(4);
    tick();
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rand_data(); a_valid = 1'b1; b_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        n_checks++;
        if (obs_busy !== 1'b0 || obs_west !== vec_t'(0) || obs_north !== vec_t'(0)) begin
          n_fail++;
          $display("FAIL midrst_clear got busy=%b west=%h north=%h want all 0", obs_busy, obs_west, obs_north);
        end
      end
      n_checks++;
      if ({obs_west, obs_north, obs_busy, obs_done} !== {exp_west, exp_north, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL midrst_quiet cyc=%0d got west=%h north=%h busy=%b done=%b want west=%h north=%h busy=%b done=%b",
                 obs_cyc, obs_west, obs_north, obs_busy, obs_done, exp_west, exp_north, exp_busy, exp_done);
      end
      if (obs_done) dones++;
    end
    start = 1'b1; len = LW'(2);
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      rand_data();
      a_valid = (accepts < 2); b_valid = (accepts < 2);
      tick();
      n_checks++;
      if ({obs_west, obs_north} !== {exp_west, exp_north}) begin
        n_fail++;
        $display("FAIL midrst_skew cyc=%0d got west=%h north=%h want west=%h north=%h",
                 obs_cyc, obs_west, obs_north, exp_west, exp_north);
      end
      if (obs_a_ready) begin accepts++; last = obs_cyc; end
      if (obs_done) begin dones++; done_at = obs_cyc; end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_checks++;
    if (accepts != 2 || dones != 1 || done_at != last + 2 * N + 1) begin
      n_fail++;
      $display("FAIL midrst_retile got accepts=%0d dones=%0d done=%0d want accepts=2 dones=1 done=%0d",
               accepts, dones, done_at, last + 2 * N + 1);
    end
  endtask

  task automatic test_back_to_back();
    int   acc_cyc[$];
    vec_t acc_data[$];
    int   idle_at = -1;
    start = 1'b1; len = LW'(1);
    a_valid = 1'b1; b_valid = 1'b1;
    for (int c = 0; c < 28; c++) begin
      rand_data();
      tick();
      n_checks++;
      if ({obs_west, obs_north} !== {exp_west, exp_north}) begin
        n_fail++;
        $display("FAIL b2b_skew cyc=%0d got west=%h north=%h want west=%h north=%h",
                 obs_cyc, obs_west, obs_north, exp_west, exp_north);
      end
      if (acc_cyc.size() > 0 && obs_cyc == acc_cyc[$] + 1) begin
        n_checks++;
        if (obs_west[0] !== acc_data[$][0]) begin
          n_fail++;
          $display("FAIL b2b_first_lane cyc=%0d got %h want %h", obs_cyc, obs_west[0], acc_data[$][0]);
        end
      end
      if (acc_cyc.size() == 1 && !obs_busy && idle_at < 0) idle_at = obs_cyc;
      if (obs_a_ready) begin
        acc_cyc.push_back(obs_cyc);
        acc_data.push_back(a_data);
        if (acc_cyc.size() == 2) start = 1'b0;
      end
    end
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    n_checks++;
    if (acc_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d accepts want 2", acc_cyc.size());
    end else begin
      n_checks++;
      if (idle_at != acc_cyc[0] + 2 * N + 2 || acc_cyc[1] != acc_cyc[0] + 2 * N + 3) begin
        n_fail++;
        $display("FAIL b2b_timing got idle=%0d second_accept=%0d want idle=%0d second_accept=%0d",
                 idle_at, acc_cyc[1], acc_cyc[0] + 2 * N + 2, acc_cyc[0] + 2 * N + 3);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    m_state = 0; m_k = 0; m_steps = 0; m_flush = 0;
    for (int i = 0; i < N; i++) begin
      hist_a.push_back('0);
      hist_b.push_back('0);
    end
    test_reset();
    test_single();
    test_stall();
    test_len_limits();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
